// File: rtl/attk_sched_pkg.sv
// Shared types, VGA timing constants and helpers for the attacker wave scheduler.
package attk_sched_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StLaunch = 3'd2,
    StRun    = 3'd3,
    StPause  = 3'd4,
    StOver   = 3'd5
  } sched_state_e;

  // 1024x768 @ 60 Hz timing, shared with the attacker sprite engines
  localparam int unsigned HFP = 24;
  localparam int unsigned HBP = 160;
  localparam int unsigned VFP = 3;
  localparam int unsigned VBP = 29;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counter that advances only on frame ticks; done pulses on the tick that reaches TERM.
module frame_tick_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 1
) (
  input  logic clk_65M,
  input  logic clear,
  input  logic tick,
  input  logic run,
  input  logic restart,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERM - 1);

  logic [WIDTH-1:0] count_q;

  assign done = run && tick && (count_q == LAST);

  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else if (restart || done) begin
      count_q <= '0;
    end else if (run && tick) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/attack_wave_scheduler.sv
// Staggers attacker launches, counts dodges into score/waves/levels and latches game over.
module attack_wave_scheduler
  import attk_sched_pkg::*;
#(
  parameter int unsigned N_ATTK       = 5,
  parameter int unsigned LAUNCH_GAP   = 30,
  parameter int unsigned WAVE_LEN     = 20,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned SCORE_W      = 16
) (
  input  logic               clk_65M,
  input  logic               clear,
  input  logic               game_on,
  input  logic               game_stop,
  input  logic [16:0]        H_count,
  input  logic [16:0]        V_count,
  input  logic [N_ATTK-1:0]  atk_over,
  input  logic [N_ATTK-1:0]  atk_wrap,
  output logic [N_ATTK-1:0]  atk_en,
  output logic [2:0]         level,
  output logic [7:0]         wave_num,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [2:0]         state_o
);

  localparam int unsigned CNT_MAX = (LAUNCH_GAP > PAUSE_FRAMES) ? LAUNCH_GAP : PAUSE_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned DODGE_W = $clog2(WAVE_LEN + N_ATTK) + 1;
  localparam int unsigned SUM_W   = SCORE_W + 1;

  localparam logic [DODGE_W-1:0] WAVE_TARGET = DODGE_W'(WAVE_LEN);
  localparam logic [2:0]         LEVEL_MAX   = 3'(MAX_LEVEL);
  localparam logic [3:0]         LAST_IDX    = 4'(N_ATTK - 1);

  sched_state_e       state_q;
  logic [3:0]         launch_idx_q;
  logic [DODGE_W-1:0] dodge_cnt_q;

  logic               frame_tick;
  logic               active;
  logic               collide;
  logic               wave_done;
  logic               gap_done;
  logic               pause_done;
  logic [7:0]         wrap_hits;
  logic [3:0]         inc;
  logic [DODGE_W-1:0] dodge_sum;
  logic [SUM_W-1:0]   score_sum;

  assign frame_tick = (H_count == '0) && (V_count == '0);
  assign active     = (state_q == StLaunch) || (state_q == StRun);
  assign collide    = active && |(atk_over & atk_en);
  assign wrap_hits  = 8'(atk_wrap & atk_en);
  assign inc        = popcount8(wrap_hits);
  assign dodge_sum  = dodge_cnt_q + DODGE_W'(inc);
  assign wave_done  = active && (dodge_sum >= WAVE_TARGET);
  assign score_sum  = {1'b0, score} + SUM_W'(inc);
  assign state_o    = state_q;

  // Gap timing only starts once the first attacker is out.
  frame_tick_counter #(
    .WIDTH (CNT_W),
    .TERM  (LAUNCH_GAP)
  ) u_gap_cnt (
    .clk_65M (clk_65M),
    .clear   (clear),
    .tick    (frame_tick),
    .run     ((state_q == StLaunch) && (launch_idx_q != 4'd0)),
    .restart (state_q != StLaunch),
    .done    (gap_done)
  );

  frame_tick_counter #(
    .WIDTH (CNT_W),
    .TERM  (PAUSE_FRAMES)
  ) u_pause_cnt (
    .clk_65M (clk_65M),
    .clear   (clear),
    .tick    (frame_tick),
    .run     (state_q == StPause),
    .restart (state_q != StPause),
    .done    (pause_done)
  );

  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      launch_idx_q <= '0;
      dodge_cnt_q  <= '0;
      atk_en       <= '0;
      level        <= '0;
      wave_num     <= '0;
      score        <= '0;
      game_over    <= 1'b0;
    end else if (game_stop) begin
      // score and wave_num stay visible until the next game is armed
      state_q      <= StIdle;
      launch_idx_q <= '0;
      dodge_cnt_q  <= '0;
      atk_en       <= '0;
      level        <= '0;
      game_over    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StArm: begin
          if (state_q == StArm || game_on) begin
            score        <= '0;
            wave_num     <= 8'd1;
            level        <= '0;
            launch_idx_q <= '0;
            dodge_cnt_q  <= '0;
            atk_en       <= '0;
            state_q      <= (state_q == StArm) ? StLaunch : StArm;
          end
        end
        StLaunch, StRun: begin
          if (collide) begin
            state_q   <= StOver;
            game_over <= 1'b1;
          end else begin
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (wave_done) begin
              state_q     <= StPause;
              atk_en      <= '0;
              dodge_cnt_q <= '0;
              level       <= (level == LEVEL_MAX) ? level : level + 3'd1;
              wave_num    <= (wave_num == 8'hff) ? wave_num : wave_num + 8'd1;
            end else begin
              dodge_cnt_q <= dodge_sum;
              if ((state_q == StLaunch) && frame_tick &&
                  ((launch_idx_q == 4'd0) || gap_done)) begin
                atk_en       <= atk_en | (N_ATTK'(1) << launch_idx_q);
                launch_idx_q <= launch_idx_q + 4'd1;
                if (launch_idx_q == LAST_IDX) begin
                  state_q <= StRun;
                end
              end
            end
          end
        end
        StPause: begin
          if (pause_done) begin
            launch_idx_q <= '0;
            state_q      <= StLaunch;
          end
        end
        StOver: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
